// File: rtl/tonegen_pkg.sv
// Shared helpers and width derivations for the polyphonic tone generator.
package tonegen_pkg;

  localparam int unsigned TICK_DIV_DEFAULT = 16000;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 32'd1;
    end
    return r;
  endfunction

  // Counter/select width that never collapses to zero bits.
  function automatic int unsigned cw_of(input int unsigned n);
    return (clog2(n) < 1) ? 32'd1 : clog2(n);
  endfunction

  // Width able to hold a count of 0..n inclusive.
  function automatic int unsigned nw_of(input int unsigned n);
    return (clog2(n + 1) < 1) ? 32'd1 : clog2(n + 1);
  endfunction

endpackage

// File: rtl/tonegen_voice.sv
// One square-wave voice: half-period divider, toggle flop and tick-based note duration.
module tonegen_voice
  import tonegen_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned DUR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 tick,
  input  logic [DIV_WIDTH-1:0] cfg_divider,
  input  logic [DUR_WIDTH-1:0] cfg_duration,
  output logic                 sq,
  output logic                 busy,
  output logic                 done
);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] phase_q, phase_d;
  logic [DUR_WIDTH-1:0] remain_q, remain_d;
  logic                 sq_q, sq_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    div_d    = div_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    sq_d     = sq_q;
    done_d   = 1'b0;
    if (load) begin
      // A write always wins over a same-cycle expiry and restarts the waveform.
      div_d    = cfg_divider;
      remain_d = cfg_duration;
      phase_d  = '0;
      sq_d     = 1'b0;
    end else if (div_q != '0) begin
      if (phase_q == div_q - DIV_WIDTH'(1)) begin
        sq_d    = ~sq_q;
        phase_d = '0;
      end else begin
        phase_d = phase_q + DIV_WIDTH'(1);
      end
      if (tick && (remain_q != '0)) begin
        if (remain_q == DUR_WIDTH'(1)) begin
          remain_d = '0;
          div_d    = '0;
          phase_d  = '0;
          sq_d     = 1'b0;
          done_d   = 1'b1;
        end else begin
          remain_d = remain_q - DUR_WIDTH'(1);
        end
      end
    end else begin
      sq_d    = 1'b0;
      phase_d = '0;
    end
    busy_d = (div_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q    <= '0;
      phase_q  <= '0;
      remain_q <= '0;
      sq_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      sq_q     <= sq_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sq   = sq_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/tonegen_poly.sv
// Polyphonic square-wave generator: CHANNELS voices mixed onto one pin by a PWM ramp.
module tonegen_poly
  import tonegen_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned DUR_WIDTH = 16,
  parameter int unsigned TICK_DIV  = TICK_DIV_DEFAULT
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cfg_we,
  input  logic [cw_of(CHANNELS)-1:0]    cfg_chan,
  input  logic [DIV_WIDTH-1:0]          cfg_divider,
  input  logic [DUR_WIDTH-1:0]          cfg_duration,
  output logic                          speaker,
  output logic [CHANNELS-1:0]           busy,
  output logic [CHANNELS-1:0]           done
);

  localparam int unsigned CW = cw_of(CHANNELS);
  localparam int unsigned NW = nw_of(CHANNELS);
  localparam int unsigned TW = cw_of(TICK_DIV);

  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [CW-1:0]       ramp_q, ramp_d;
  logic                speaker_q, speaker_d;
  logic                tick;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] sq_vec;
  logic [NW-1:0]       nhigh;

  // Channel decode; selects beyond CHANNELS-1 match no voice and are dropped.
  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      load[i] = cfg_we && (cfg_chan == CW'(i));
    end
  end

  // Prescaler, ramp and popcount mixer.
  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    ramp_d     = (ramp_q == CW'(CHANNELS - 1)) ? '0 : ramp_q + CW'(1);
    nhigh      = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      nhigh = nhigh + NW'(sq_vec[i]);
    end
    speaker_d = (NW'(ramp_q) < nhigh);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_cnt_q <= '0;
      ramp_q     <= '0;
      speaker_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      ramp_q     <= ramp_d;
      speaker_q  <= speaker_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    tonegen_voice #(
      .DIV_WIDTH (DIV_WIDTH),
      .DUR_WIDTH (DUR_WIDTH)
    ) u_voice (
      .clk          (clk),
      .resetn       (resetn),
      .load         (load[g]),
      .tick         (tick),
      .cfg_divider  (cfg_divider),
      .cfg_duration (cfg_duration),
      .sq           (sq_vec[g]),
      .busy         (busy[g]),
      .done         (done[g])
    );
  end

  assign speaker = speaker_q;

endmodule

// File: tb/tb_tonegen_poly.sv
// Randomised and directed checks of tonegen_poly against an elapsed-time reference model.
module tb_tonegen_poly;

  localparam int unsigned C  = 4;
  localparam int unsigned TD = 10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_chan = '0;
  logic [23:0] cfg_divider = '0;
  logic [15:0] cfg_duration = '0;
  logic        speaker;
  logic [3:0]  busy;
  logic [3:0]  done;

  logic        c3_we = 1'b0;
  logic [1:0]  c3_chan = '0;
  logic [23:0] c3_divider = '0;
  logic [15:0] c3_duration = '0;
  logic        speaker3;
  logic [2:0]  busy3;
  logic [2:0]  done3;

  int checks = 0;
  int errors = 0;

  tonegen_poly #(.CHANNELS(4), .DIV_WIDTH(24), .DUR_WIDTH(16), .TICK_DIV(10)) dut (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_divider(cfg_divider), .cfg_duration(cfg_duration),
    .speaker(speaker), .busy(busy), .done(done)
  );

  tonegen_poly #(.CHANNELS(3), .DIV_WIDTH(24), .DUR_WIDTH(16), .TICK_DIV(10)) dut3 (
    .clk(clk), .resetn(resetn), .cfg_we(c3_we), .cfg_chan(c3_chan),
    .cfg_divider(c3_divider), .cfg_duration(c3_duration),
    .speaker(speaker3), .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  // Reference: each voice's square wave is a function of edges elapsed since its write,
  // and its expiry is the dur-th prescaler tick after the write.
  int unsigned m_cyc = 0;
  int unsigned m_div [C];
  int unsigned m_start [C];
  int unsigned m_dur [C];
  int unsigned m_ticks [C];
  logic [C-1:0] m_sq = '0;
  logic [C-1:0] m_busy = '0;
  logic [C-1:0] m_done = '0;
  logic         m_speaker = 1'b0;

  always @(posedge clk) begin : model
    int unsigned nh;
    bit tk;
    if (!resetn) begin
      m_cyc = 0;
      m_sq = '0; m_busy = '0; m_done = '0; m_speaker = 1'b0;
      for (int i = 0; i < C; i++) begin
        m_div[i] = 0; m_start[i] = 0; m_dur[i] = 0; m_ticks[i] = 0;
      end
    end else begin
      m_cyc = m_cyc + 1;
      tk = ((m_cyc % TD) == 0);
      nh = $countones(m_sq);
      m_speaker = (((m_cyc - 1) % C) < nh);
      for (int i = 0; i < C; i++) begin
        m_done[i] = 1'b0;
        if (cfg_we && (int'(cfg_chan) == i)) begin
          m_div[i] = cfg_divider; m_dur[i] = cfg_duration;
          m_start[i] = m_cyc; m_ticks[i] = 0;
        end else if (m_div[i] != 0 && tk && m_dur[i] != 0) begin
          m_ticks[i] = m_ticks[i] + 1;
          if (m_ticks[i] == m_dur[i]) begin
            m_div[i] = 0;
            m_done[i] = 1'b1;
          end
        end
        m_sq[i]   = (m_div[i] != 0) ? ((((m_cyc - m_start[i]) / m_div[i]) % 2) == 1) : 1'b0;
        m_busy[i] = (m_div[i] != 0);
      end
    end
  end

  // Issue one write; called just after a falling edge, returns after the next one.
  task automatic wr(input int ch, input int unsigned dv, input int unsigned du);
    cfg_we = 1'b1; cfg_chan = 2'(ch); cfg_divider = 24'(dv); cfg_duration = 16'(du);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 4'b0 || done !== 4'b0 || speaker !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: busy=%b done=%b spk=%b, want 0/0/0", busy, done, speaker);
    end
    wr(0, 2, 0);
    wr(1, 3, 1);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 4'b0 || done !== 4'b0 || speaker !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: busy=%b done=%b spk=%b, want 0/0/0", busy, done, speaker);
      end
    end
    resetn = 1'b1;
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (busy !== 4'b0 || done !== 4'b0 || speaker !== 1'b0) begin
        errors++;
        $display("FAIL reset_after: busy=%b done=%b spk=%b, want silent", busy, done, speaker);
      end
    end
  endtask

  task automatic test_single;
    int ndone = 0;
    wr(0, 5, 0);
    repeat (60) begin
      checks++;
      if (busy !== m_busy || done !== m_done || speaker !== m_speaker) begin
        errors++;
        $display("FAIL single: busy=%b done=%b spk=%b, want %b/%b/%b",
                 busy, done, speaker, m_busy, m_done, m_speaker);
      end
      if (done !== 4'b0) ndone++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 4'b0001 || ndone != 0) begin
      errors++;
      $display("FAIL single_end: busy=%b dones=%0d, want 0001 and 0", busy, ndone);
    end
  endtask

  task automatic test_duration;
    int n = 0;
    bit seen = 0;
    wr(1, 3, 3);
    for (int k = 0; k < 100; k++) begin
      if (done !== 4'b0) begin seen = 1; break; end
      if (busy[1]) n++;
      checks++;
      if (speaker !== m_speaker) begin
        errors++;
        $display("FAIL dur_speaker: got %b want %b", speaker, m_speaker);
      end
      @(negedge clk);
    end
    checks++;
    if (!seen || done !== 4'b0010) begin
      errors++;
      $display("FAIL dur_done: got %b (seen=%0d), want 0010", done, seen);
    end
    checks++;
    if (n < 20 || n > 30 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL dur_len: busy1 cycles=%0d busy1=%b, want 20..30 and 0", n, busy[1]);
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0) begin
      errors++;
      $display("FAIL dur_pulse_width: done=%b, want 0000", done);
    end
  endtask

  task automatic test_mix;
    int got = 0, exp = 0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    wr(0, 1, 0);
    @(negedge clk);
    wr(1, 1, 0);
    repeat (40) begin
      checks++;
      if (speaker !== m_speaker) begin
        errors++;
        $display("FAIL mix: spk=%b want %b (cyc %0d)", speaker, m_speaker, m_cyc);
      end
      if (speaker) got++;
      if (m_speaker) exp++;
      @(negedge clk);
    end
    checks++;
    if (got != exp || busy !== 4'b0011) begin
      errors++;
      $display("FAIL mix_count: highs=%0d busy=%b, want %0d and 0011", got, busy, exp);
    end
  endtask

  task automatic test_collision;
    int ndone2 = 0;
    for (int k = 0; k < 20 && ((m_cyc + 1) % TD) != 3; k++) @(negedge clk);
    wr(2, 4, 1);
    wr(3, 5, 1);
    for (int k = 0; k < 20 && ((m_cyc + 1) % TD) != 0; k++) @(negedge clk);
    wr(2, 7, 0);
    checks++;
    if (done !== 4'b1000 || busy[3:2] !== 2'b01) begin
      errors++;
      $display("FAIL collide_edge: done=%b busy=%b, want done 1000 busy[3:2] 01", done, busy);
    end
    repeat (40) begin
      checks++;
      if (busy !== m_busy || speaker !== m_speaker) begin
        errors++;
        $display("FAIL collide_run: busy=%b spk=%b, want %b/%b", busy, speaker, m_busy, m_speaker);
      end
      if (done[2]) ndone2++;
      @(negedge clk);
    end
    checks++;
    if (ndone2 != 0 || busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL collide_keep: done2 pulses=%0d busy2=%b, want 0 and 1", ndone2, busy[2]);
    end
  endtask

  task automatic test_silence;
    wr(0, 5, 0);
    @(negedge clk);
    wr(0, 0, 0);
    checks++;
    if (busy[0] !== 1'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL silence: busy0=%b done=%b, want 0 and 0000", busy[0], done);
    end
    c3_we = 1'b1; c3_chan = 2'd0; c3_divider = 24'd4; c3_duration = 16'd0;
    @(negedge clk);
    c3_chan = 2'd3; c3_divider = 24'd9; c3_duration = 16'd2;
    @(negedge clk);
    c3_divider = 24'd0; c3_duration = 16'd0;
    @(negedge clk);
    c3_we = 1'b0;
    repeat (30) begin
      checks++;
      if (busy3 !== 3'b001 || done3 !== 3'b000) begin
        errors++;
        $display("FAIL out_of_range: busy3=%b done3=%b, want 001/000", busy3, done3);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    repeat (400) begin
      checks++;
      if (busy !== m_busy || done !== m_done || speaker !== m_speaker) begin
        errors++;
        $display("FAIL random: busy=%b done=%b spk=%b, want %b/%b/%b (cyc %0d)",
                 busy, done, speaker, m_busy, m_done, m_speaker, m_cyc);
      end
      if ($urandom_range(0, 3) == 0) begin
        cfg_we = 1'b1;
        cfg_chan = 2'($urandom_range(0, 3));
        cfg_divider = 24'($urandom_range(0, 6));
        cfg_duration = 16'($urandom_range(0, 4));
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_duration;
    test_mix;
    test_collision;
    test_silence;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
